// File: rtl/loongarch_pkg.sv
`default_nettype none
// ============================================================================
//  Package : loongarch_pkg
//  Purpose : Shared constants and types for the multi-cycle LoongArch core:
//            default reset PC, instruction-fetch state encoding, canonical
//            NOP encoding, the ADE exception code and a small alignment helper.
//  Revision: 1.0 - initial release
// ============================================================================
package loongarch_pkg;

  // PC of the first instruction fetched after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

  // Fetch FSM encoding.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FS_IDLE  = 2'd0;
  localparam fetch_state_t FS_REQ   = 2'd1;
  localparam fetch_state_t FS_WAIT  = 2'd2;
  localparam fetch_state_t FS_VALID = 2'd3;

  // andi r0, r0, 0
  localparam logic [31:0] INST_NOP = 32'h03400000;

  // Address-error exception code; ADEF is esubcode 0 of this ecode.
  localparam logic [5:0] ECODE_ADE = 6'h08;

  // Instructions are word aligned; any low address bit set is an ADEF.
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module  : if_fetch_stage
//  Purpose : Instruction-fetch front end. Owns the architectural PC, reads the
//            synchronous inst SRAM (1-cycle latency) and presents
//            {pc, inst, adef} to decode over a valid/ready handshake.
//            Redirects from execute restart fetch at a new target.
//  Ports   :
//    clk, reset                      clock, synchronous active-high reset
//    inst_sram_en/we/addr/wdata      SRAM read request (we/wdata tied 0)
//    inst_sram_rdata                 SRAM read data, valid cycle after en
//    redirect_valid, redirect_pc     one-cycle restart request and target
//    fs_valid, fs_ready              handshake with decode
//    fs_pc, fs_inst, fs_adef         presented instruction and its ADEF flag
//  Revision: 1.0 - initial release
// ============================================================================
module if_fetch_stage
  import loongarch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fs_valid,
  input  logic        fs_ready,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adef
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q,    pc_d;
  logic [31:0]  inst_q,  inst_d;
  logic         adef_q,  adef_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      adef_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      adef_q  <= adef_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-PC logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    adef_d  = adef_q;

    if (redirect_valid) begin
      // Redirect wins over everything: any read in flight and any held
      // instruction are abandoned, fetch restarts at the target.
      state_d = FS_REQ;
      pc_d    = redirect_pc;
    end else begin
      case (state_q)
        FS_IDLE: state_d = FS_REQ;
        FS_REQ: begin
          if (pc_misaligned(pc_q)) begin
            // No SRAM access for a misaligned PC; present an ADEF bubble.
            inst_d  = 32'h0;
            adef_d  = 1'b1;
            state_d = FS_VALID;
          end else begin
            state_d = FS_WAIT;
          end
        end
        FS_WAIT: begin
          inst_d  = inst_sram_rdata;
          adef_d  = 1'b0;
          state_d = FS_VALID;
        end
        FS_VALID: begin
          if (fs_ready) begin
            pc_d    = pc_q + 32'd4;  // wraps silently at 2^32
            state_d = FS_REQ;
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    inst_sram_en = (state_q == FS_REQ) && !pc_misaligned(pc_q);
    fs_valid     = (state_q == FS_VALID);
  end

  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = pc_q;
  assign fs_pc           = pc_q;
  assign fs_inst         = inst_q;
  assign fs_adef         = adef_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_if_fetch_stage
//  Purpose : Self-checking bench for if_fetch_stage. A program-order model
//            (next expected {pc, inst, adef}) is kept in a queue; the stimulus
//            side rewrites it on redirect/reset, a monitor pops and compares on
//            every accepted transfer. Directed sequences cover latency, stall,
//            redirect, ADEF and mid-operation reset; a random phase follows.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  localparam logic [31:0] C_RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'hdeadbeef;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fs_valid;
  logic        fs_ready;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adef;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } exp_t;

  exp_t sb[$];

  if_fetch_stage #(.RESET_PC(C_RESET_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fs_valid        (fs_valid),
    .fs_ready        (fs_ready),
    .fs_pc           (fs_pc),
    .fs_inst         (fs_inst),
    .fs_adef         (fs_adef)
  );

  always #5 clk = ~clk;

  // Address-derived memory contents: a bijection, so every word is distinct.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5ac3c3;
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.adef = (pc[1:0] != 2'b00);
    e.inst = e.adef ? 32'h0 : memw(pc);
    return e;
  endfunction

  // Synchronous SRAM, one-cycle read latency.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= memw(inst_sram_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_restart(input logic [31:0] pc);
    sb.delete();
    sb.push_back(mk(pc));
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    model_restart(pc);
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!fs_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!fs_valid) begin
      failures++;
      $display("FAIL wait_valid timeout actual=0 expected=1 at %0t", $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'h0, fs_valid}, 32'h0);
    chk({tag, "_adef"},  {31'h0, fs_adef},  32'h0);
    chk({tag, "_inst"},  fs_inst,           32'h0);
    chk({tag, "_pc"},    fs_pc,             C_RESET_PC);
    chk({tag, "_en"},    {31'h0, inst_sram_en}, 32'h0);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (inst_sram_en) begin
        chk("en_addr_is_pc", inst_sram_addr, fs_pc);
        chk("en_addr_aligned", {30'h0, inst_sram_addr[1:0]}, 32'h0);
      end
      if (fs_valid && fs_ready && !redirect_valid) begin
        xfers++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty actual=pc %h expected=no transfer", fs_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("xfer_pc",   fs_pc,   e.pc);
          chk("xfer_inst", fs_inst, e.inst);
          chk("xfer_adef", {31'h0, fs_adef}, {31'h0, e.adef});
          sb.push_back(mk(e.pc + 32'd4));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p, i;
    int          n;
    int          x0;

    reset          = 1'b1;
    fs_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_restart(C_RESET_PC);
    cyc(); cyc();
    @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_we",    {31'h0, inst_sram_we}, 32'h0);
    chk("rst_wdata", inst_sram_wdata,       32'h0);

    // 1: first fetch latency
    cyc(); reset = 1'b0;
    cyc(); @(negedge clk);
    chk("t1_en",    {31'h0, inst_sram_en}, 32'h1);
    chk("t1_addr",  inst_sram_addr,        C_RESET_PC);
    chk("t1_valid0", {31'h0, fs_valid},    32'h0);
    cyc(); @(negedge clk);
    chk("t1_wait_valid", {31'h0, fs_valid}, 32'h0);
    chk("t1_wait_en",    {31'h0, inst_sram_en}, 32'h0);
    cyc(); @(negedge clk);
    chk("t1_valid", {31'h0, fs_valid}, 32'h1);
    chk("t1_pc",    fs_pc,   C_RESET_PC);
    chk("t1_inst",  fs_inst, memw(C_RESET_PC));

    // 2: steady throughput, one transfer every 3 cycles
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!fs_valid && n < 10);
      chk("t2_gap", n, 3);
      chk("t2_pc",  fs_pc, C_RESET_PC + 32'd4 * (k + 1));
    end

    // 3: stall in VALID
    cyc(); fs_ready = 1'b0;
    wait_valid();
    p = fs_pc;
    i = fs_inst;
    for (int k = 0; k < 5; k++) begin
      cyc(); @(negedge clk);
      chk("t3_valid", {31'h0, fs_valid}, 32'h1);
      chk("t3_pc",    fs_pc,   p);
      chk("t3_inst",  fs_inst, i);
      chk("t3_en",    {31'h0, inst_sram_en}, 32'h0);
    end
    cyc(); fs_ready = 1'b1;
    @(negedge clk);
    cyc(); @(negedge clk);
    chk("t3_next_en",   {31'h0, inst_sram_en}, 32'h1);
    chk("t3_next_addr", inst_sram_addr, p + 32'd4);

    // 4a: redirect in WAIT
    cyc(); do_redirect(32'h1c000100);
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_en",    {31'h0, inst_sram_en}, 32'h1);
    chk("t4_addr",  inst_sram_addr, 32'h1c000100);
    chk("t4_valid", {31'h0, fs_valid}, 32'h0);
    // 4b: redirect in VALID with ready high
    cyc(); fs_ready = 1'b0;
    wait_valid();
    chk("t4_held_pc", fs_pc, 32'h1c000100);
    cyc(); fs_ready = 1'b1; do_redirect(32'h1c000200);
    @(negedge clk);
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4b_valid", {31'h0, fs_valid}, 32'h0);
    chk("t4b_en",    {31'h0, inst_sram_en}, 32'h1);
    chk("t4b_addr",  inst_sram_addr, 32'h1c000200);

    // 5: misaligned redirect target
    cyc(); do_redirect(32'h1c000102); fs_ready = 1'b0;
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_en",    {31'h0, inst_sram_en}, 32'h0);
    chk("t5_pc",    fs_pc, 32'h1c000102);
    cyc(); @(negedge clk);
    chk("t5_valid", {31'h0, fs_valid}, 32'h1);
    chk("t5_adef",  {31'h0, fs_adef},  32'h1);
    chk("t5_inst",  fs_inst, 32'h0);
    cyc(); fs_ready = 1'b1;
    @(negedge clk);

    // 6a: reset in WAIT
    cyc(); do_redirect(32'h1c000300);
    cyc(); redirect_valid = 1'b0;
    cyc(); reset = 1'b1; model_restart(C_RESET_PC);
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("t6w");
    cyc(); @(negedge clk);
    chk("t6w_en",   {31'h0, inst_sram_en}, 32'h1);
    chk("t6w_addr", inst_sram_addr, C_RESET_PC);
    // 6b: reset in VALID
    cyc(); fs_ready = 1'b0;
    wait_valid();
    cyc(); reset = 1'b1; model_restart(C_RESET_PC);
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("t6v");
    cyc(); fs_ready = 1'b1;
    @(negedge clk);
    chk("t6v_en",   {31'h0, inst_sram_en}, 32'h1);
    chk("t6v_addr", inst_sram_addr, C_RESET_PC);

    // Random phase
    x0 = xfers;
    for (int k = 0; k < 3000; k++) begin
      cyc();
      fs_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 7))
          0:       do_redirect(32'hfffffff8);
          1:       do_redirect(32'h1c000000 + ($urandom % 1024) * 4 + $urandom_range(0, 3));
          default: do_redirect(32'h1c000000 + ($urandom % 1024) * 4);
        endcase
      end else begin
        redirect_valid = 1'b0;
      end
    end
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (xfers - x0 < 200) begin
      failures++;
      $display("FAIL rand_xfer_count actual=%0d expected>=200", xfers - x0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
